// File: rtl/gpt2_gen_pkg.sv
// Shared types for the GPT-2 generation sequencer: FSM states, stop codes
// and the width helper used to size token/position/layer fields.
package gpt2_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EMBED, S_LAYER, S_FINAL_LN, S_LMHEAD, S_EMIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    STOP_NONE = 2'd0,
    STOP_LEN  = 2'd1,
    STOP_EOS  = 2'd2,
    STOP_CTX  = 2'd3
  } stop_t;

  // Field width for n distinct values, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpt2_gen_sequencer_argmax.sv
// Streaming argmax over one LM-head pass: strict signed compare, so the
// lowest index wins ties.
module vocab_argmax_stream
  import gpt2_gen_pkg::*;
#(
  parameter int VOCAB_SIZE = 16,
  parameter int DATA_WIDTH = 16,
  localparam int TOK_W     = clog2w(VOCAB_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic        [TOK_W-1:0]      arg,
  output logic signed [DATA_WIDTH-1:0] max,
  output logic                         last
);

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [TOK_W-1:0]             LAST_IDX = TOK_W'(VOCAB_SIZE - 1);

  logic [TOK_W-1:0] idx;

  assign last = valid && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      arg <= '0;
      max <= MOST_NEG;
    end else if (clear) begin
      idx <= '0;
      arg <= '0;
      max <= MOST_NEG;
    end else if (valid) begin
      if (data > max) begin
        max <= data;
        arg <= idx;
      end
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/gpt2_gen_sequencer.sv
// Token-by-token GPT-2 generation controller: consumes a prompt, steps the
// external embed/block/LN/LM-head datapath and streams out argmax tokens.
module gpt2_gen_sequencer
  import gpt2_gen_pkg::*;
#(
  parameter int VOCAB_SIZE  = 16,
  parameter int MAX_SEQ_LEN = 8,
  parameter int NUM_LAYERS  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int EOS_EN      = 1,
  localparam int TOK_W      = clog2w(VOCAB_SIZE),
  localparam int POS_W      = clog2w(MAX_SEQ_LEN),
  localparam int LAYER_W    = clog2w(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [POS_W:0]        gen_len,
  input  logic [TOK_W-1:0]      eos_token,
  input  logic                  abort,
  input  logic                  prompt_valid,
  output logic                  prompt_ready,
  input  logic [TOK_W-1:0]      prompt_token,
  input  logic                  prompt_last,
  output logic                  emb_req,
  input  logic                  emb_ack,
  output logic [TOK_W-1:0]      emb_token,
  output logic [POS_W-1:0]      emb_pos,
  output logic                  layer_req,
  input  logic                  layer_ack,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic                  lnf_req,
  input  logic                  lnf_ack,
  input  logic                  logit_valid,
  input  logic [DATA_WIDTH-1:0] logit_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOK_W-1:0]      out_token,
  output logic [POS_W-1:0]      out_pos,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            stop_reason
);

  localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(MAX_SEQ_LEN - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t            state;
  logic              gen_phase;
  logic              is_last;
  logic [TOK_W-1:0]  cur_tok;
  logic [POS_W-1:0]  pos;
  logic [POS_W:0]    gen_cnt;
  logic [POS_W:0]    gen_len_q;
  logic [TOK_W-1:0]  eos_q;
  stop_t             pend_stop;
  stop_t             stop_nxt;
  logic [POS_W:0]    cnt_nxt;

  logic                         am_clear;
  logic                         am_valid;
  logic                         am_last;
  logic [TOK_W-1:0]             am_arg;
  logic signed [DATA_WIDTH-1:0] am_max_unused;

  assign busy      = (state != S_IDLE);
  assign emb_token = cur_tok;
  assign emb_pos   = pos;
  assign am_clear  = (state == S_FINAL_LN);
  assign am_valid  = logit_valid && (state == S_LMHEAD);
  assign cnt_nxt   = gen_cnt + 1'b1;

  vocab_argmax_stream #(
    .VOCAB_SIZE (VOCAB_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_argmax (
    .clk   (clk),
    .rst   (rst),
    .clear (am_clear),
    .valid (am_valid),
    .data  ($signed(logit_data)),
    .arg   (am_arg),
    .max   (am_max_unused),
    .last  (am_last)
  );

  // EOS outranks length, which outranks running out of context.
  always_comb begin
    stop_nxt = STOP_NONE;
    if ((EOS_EN != 0) && (am_arg == eos_q)) stop_nxt = STOP_EOS;
    else if (cnt_nxt == gen_len_q)          stop_nxt = STOP_LEN;
    else if (pos == LAST_POS)               stop_nxt = STOP_CTX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      gen_phase    <= 1'b0;
      is_last      <= 1'b0;
      cur_tok      <= '0;
      pos          <= '0;
      gen_cnt      <= '0;
      gen_len_q    <= '0;
      eos_q        <= '0;
      pend_stop    <= STOP_NONE;
      prompt_ready <= 1'b0;
      emb_req      <= 1'b0;
      layer_req    <= 1'b0;
      layer_idx    <= '0;
      lnf_req      <= 1'b0;
      out_valid    <= 1'b0;
      out_token    <= '0;
      out_pos      <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
      stop_reason  <= STOP_NONE;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state        <= S_IDLE;
        prompt_ready <= 1'b0;
        emb_req      <= 1'b0;
        layer_req    <= 1'b0;
        lnf_req      <= 1'b0;
        out_valid    <= 1'b0;
        out_last     <= 1'b0;
        stop_reason  <= STOP_NONE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            gen_len_q   <= gen_len;
            eos_q       <= eos_token;
            stop_reason <= STOP_NONE;
            if (gen_len == '0) begin
              stop_reason <= STOP_LEN;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              pos       <= '0;
              gen_cnt   <= '0;
              gen_phase <= 1'b0;
              is_last   <= 1'b0;
              state     <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (gen_phase) state <= S_EMBED;
            else if (!prompt_ready) prompt_ready <= 1'b1;
            else if (prompt_valid) begin
              prompt_ready <= 1'b0;
              cur_tok      <= prompt_token;
              is_last      <= prompt_last;
              state        <= S_EMBED;
            end
          end
          S_EMBED: begin
            if (!emb_req) emb_req <= 1'b1;
            else if (emb_ack) begin
              emb_req   <= 1'b0;
              layer_idx <= '0;
              state     <= S_LAYER;
            end
          end
          S_LAYER: begin
            if (!layer_req) layer_req <= 1'b1;
            else if (layer_ack) begin
              layer_req <= 1'b0;
              layer_idx <= layer_idx + 1'b1;
              if (layer_idx == LAST_LAYER) begin
                // Non-final prompt tokens only warm the context; no LM head.
                if (!gen_phase && !is_last) begin
                  if (pos == LAST_POS) begin
                    stop_reason <= STOP_CTX;
                    done        <= 1'b1;
                    state       <= S_DONE;
                  end else begin
                    pos   <= pos + 1'b1;
                    state <= S_FETCH;
                  end
                end else begin
                  state <= S_FINAL_LN;
                end
              end
            end
          end
          S_FINAL_LN: begin
            if (!lnf_req) lnf_req <= 1'b1;
            else if (lnf_ack) begin
              lnf_req <= 1'b0;
              state   <= S_LMHEAD;
            end
          end
          S_LMHEAD: if (am_last) state <= S_EMIT;
          S_EMIT: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_token <= am_arg;
              out_pos   <= pos;
              out_last  <= (stop_nxt != STOP_NONE);
              pend_stop <= stop_nxt;
            end else if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              gen_cnt   <= cnt_nxt;
              if (pend_stop != STOP_NONE) begin
                stop_reason <= pend_stop;
                done        <= 1'b1;
                state       <= S_DONE;
              end else begin
                gen_phase <= 1'b1;
                pos       <= pos + 1'b1;
                cur_tok   <= out_token;
                state     <= S_FETCH;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpt2_gen_sequencer.sv
// Randomized bench for gpt2_gen_sequencer: random handshake timing against a
// job-level model of prompt consumption, argmax generation and stop rules.
module tb_gpt2_gen_sequencer;

  localparam int VS  = 16;
  localparam int MSL = 8;
  localparam int NL  = 4;

  typedef struct { int tok; int pos; int last; } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, abort = 0;
  logic [3:0] gen_len = '0, eos_token = '0, prompt_token = '0;
  logic prompt_valid = 0, prompt_last = 0, prompt_ready;
  logic emb_req, emb_ack = 0, layer_req, layer_ack = 0, lnf_req, lnf_ack = 0;
  logic [3:0] emb_token, out_token;
  logic [2:0] emb_pos, out_pos;
  logic [1:0] layer_idx, stop_reason;
  logic logit_valid = 0;
  logic [15:0] logit_data = '0;
  logic out_valid, out_ready = 0, out_last, busy, done;

  int n_tests = 0, n_fail = 0;
  int prm[$];
  int prm_i = 0, pass_k = 0, lidx = 0, lcnt = 0;
  bit streaming = 0, hold_env = 0, ready_lo = 0;
  logic signed [15:0] lg [8][VS];
  beat_t obs_emb[$], exp_emb[$], obs_out[$], exp_out[$];
  int obs_layer = 0, obs_lnf = 0, done_n = 0, d0 = 0, exp_stop = 0;
  int t, snap, snap_pos, req_seen;

  gpt2_gen_sequencer #(.VOCAB_SIZE(VS), .MAX_SEQ_LEN(MSL), .NUM_LAYERS(NL),
                       .DATA_WIDTH(16), .EOS_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .gen_len(gen_len), .eos_token(eos_token),
    .abort(abort), .prompt_valid(prompt_valid), .prompt_ready(prompt_ready),
    .prompt_token(prompt_token), .prompt_last(prompt_last),
    .emb_req(emb_req), .emb_ack(emb_ack), .emb_token(emb_token), .emb_pos(emb_pos),
    .layer_req(layer_req), .layer_ack(layer_ack), .layer_idx(layer_idx),
    .lnf_req(lnf_req), .lnf_ack(lnf_ack), .logit_valid(logit_valid),
    .logit_data(logit_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_token(out_token), .out_pos(out_pos), .out_last(out_last),
    .busy(busy), .done(done), .stop_reason(stop_reason));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int argmax(input int k);
    int best = 0;
    for (int v = 1; v < VS; v++) if (lg[k][v] > lg[k][best]) best = v;
    return best;
  endfunction

  // Whole-job expectation: what gets embedded, what gets emitted, why it stops.
  task automatic model(input int g, input int e);
    int p, cnt, a, st;
    exp_emb.delete(); exp_out.delete(); exp_stop = 0;
    if (g == 0) begin exp_stop = 1; return; end
    for (int i = 0; i < prm.size(); i++) begin
      exp_emb.push_back('{prm[i], i, 0});
      if (i == prm.size() - 1) break;
      if (i == MSL - 1) begin exp_stop = 3; return; end
    end
    p = prm.size() - 1; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      a = argmax(k); cnt++;
      st = (a == e) ? 2 : (cnt == g) ? 1 : (p == MSL - 1) ? 3 : 0;
      exp_out.push_back('{a, p, (st != 0) ? 1 : 0});
      if (st != 0) begin exp_stop = st; return; end
      p++;
      exp_emb.push_back('{a, p, 0});
    end
  endtask

  // Environment driver: random acks, prompt and logit streams, sink readiness.
  always @(posedge clk) begin
    #1;
    if (!hold_env) begin
      emb_ack   = ($urandom % 3) != 0;
      layer_ack = ($urandom % 3) != 0;
      lnf_ack   = ($urandom % 3) != 0;
    end
    out_ready = ready_lo ? 1'b0 : (($urandom % 4) != 0);
    if (prm_i < prm.size()) begin
      prompt_valid = ($urandom % 4) != 0;
      prompt_token = 4'(prm[prm_i]);
      prompt_last  = (prm_i == prm.size() - 1);
    end else prompt_valid = 1'b0;
    if (streaming && lidx < VS) begin
      logit_valid = ($urandom % 3) != 0;
      logit_data  = lg[pass_k & 7][lidx];
    end else logit_valid = 1'b0;
  end

  // Monitor: every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (!rst) begin
      if (prompt_valid && prompt_ready) prm_i++;
      if (logit_valid && streaming) begin
        lidx++;
        if (lidx == VS) begin streaming = 0; pass_k++; end
      end
      if (emb_req && emb_ack) begin
        obs_emb.push_back('{int'(emb_token), int'(emb_pos), 0});
        lcnt = 0;
      end
      if (layer_req && layer_ack) begin
        chk("layer_idx", 32'(layer_idx), 32'(lcnt));
        lcnt++; obs_layer++;
      end
      if (lnf_req && lnf_ack) begin obs_lnf++; streaming = 1; lidx = 0; end
      if (out_valid && out_ready)
        obs_out.push_back('{int'(out_token), int'(out_pos), int'(out_last)});
      if (done) done_n++;
    end
  end

  task automatic fill_rand(input int narrow);
    for (int k = 0; k < 8; k++)
      for (int v = 0; v < VS; v++)
        lg[k][v] = narrow ? 16'($urandom_range(0, 7)) - 16'sd4 : 16'($urandom);
  endtask

  task automatic set_peak(input int k, input int v);
    for (int u = 0; u < VS; u++) lg[k][u] = 16'($urandom_range(0, 1000)) - 16'sd500;
    lg[k][v] = 16'sd2000;
  endtask

  task automatic start_job(input int g, input int e);
    @(negedge clk);
    prm_i = 0; pass_k = 0; streaming = 0; lidx = 0; lcnt = 0;
    obs_emb.delete(); obs_out.delete(); obs_layer = 0; obs_lnf = 0; d0 = done_n;
    model(g, e);
    gen_len = 4'(g); eos_token = 4'(e);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int w = 0;
    while (done_n == d0 && w < 4000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk({tag, ".done_pulses"}, 32'(done_n - d0), 1);
    chk({tag, ".stop_reason"}, 32'(stop_reason), 32'(exp_stop));
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".emb_count"}, 32'(obs_emb.size()), 32'(exp_emb.size()));
    for (int i = 0; i < obs_emb.size() && i < exp_emb.size(); i++) begin
      chk({tag, ".emb_token"}, 32'(obs_emb[i].tok), 32'(exp_emb[i].tok));
      chk({tag, ".emb_pos"}, 32'(obs_emb[i].pos), 32'(exp_emb[i].pos));
    end
    chk({tag, ".layer_count"}, 32'(obs_layer), 32'(NL * exp_emb.size()));
    chk({tag, ".lnf_count"}, 32'(obs_lnf), 32'(exp_out.size()));
    chk({tag, ".out_count"}, 32'(obs_out.size()), 32'(exp_out.size()));
    for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
      chk({tag, ".out_token"}, 32'(obs_out[i].tok), 32'(exp_out[i].tok));
      chk({tag, ".out_pos"}, 32'(obs_out[i].pos), 32'(exp_out[i].pos));
      chk({tag, ".out_last"}, 32'(obs_out[i].last), 32'(exp_out[i].last));
    end
  endtask

  function automatic int first_out();
    return (obs_out.size() > 0) ? obs_out[0].tok : -1;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.reqs", 32'({emb_req, layer_req, lnf_req}), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.prompt_ready", 32'(prompt_ready), 0);
    chk("rst.stop_reason", 32'(stop_reason), 0);
    @(posedge clk); #1 rst = 1'b0;

    prm = '{3, 5}; fill_rand(0); set_peak(0, 7); set_peak(1, 9);
    start_job(2, 0); finish_job("basic");

    prm = '{1}; fill_rand(0);
    for (int v = 0; v < VS; v++) lg[0][v] = -16'sd5;
    lg[0][2] = 16'sd100; lg[0][6] = 16'sd100;
    start_job(1, 15); finish_job("tie");
    chk("tie.token", 32'(first_out()), 2);

    prm = '{2}; fill_rand(0);
    for (int v = 0; v < VS; v++) lg[0][v] = 16'sh8000;
    start_job(1, 15); finish_job("allmin");
    chk("allmin.token", 32'(first_out()), 0);

    prm = '{6}; fill_rand(0); set_peak(0, 4);
    start_job(5, 4); finish_job("eos");

    prm = '{1, 2, 3, 4, 5, 6}; fill_rand(0); set_peak(0, 8); set_peak(1, 9); set_peak(2, 10);
    start_job(7, 0); finish_job("ctx");

    prm = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; fill_rand(0);
    start_job(3, 0); finish_job("longprompt");

    prm = '{1}; start_job(0, 0); finish_job("len0");

    // Backpressure: a stalled beat must not change.
    prm = '{7, 8}; fill_rand(0); set_peak(0, 5); set_peak(1, 6); set_peak(2, 11);
    ready_lo = 1;
    start_job(3, 0);
    t = 0;
    while (!out_valid && t < 2000) begin @(negedge clk); t++; end
    snap = int'(out_token); snap_pos = int'(out_pos);
    chk("bp.first_token", 32'(snap), 32'(exp_out[0].tok));
    repeat (10) begin
      @(negedge clk);
      chk("bp.valid", 32'(out_valid), 1);
      chk("bp.token", 32'(out_token), 32'(snap));
      chk("bp.pos", 32'(out_pos), 32'(snap_pos));
    end
    ready_lo = 0;
    finish_job("bp");

    // Abort coinciding with a layer ack.
    prm = '{1, 2}; fill_rand(0); start_job(3, 0);
    t = 0;
    while (!(layer_req && layer_idx == 2'd0) && t < 2000) begin @(negedge clk); t++; end
    hold_env = 1;
    @(posedge clk); #2 emb_ack = 0; layer_ack = 0; lnf_ack = 0;
    t = 0;
    @(negedge clk);
    while (!layer_req && t < 100) begin @(negedge clk); t++; end
    req_seen = int'(layer_req);
    @(posedge clk); #2 abort = 1; layer_ack = 1;
    @(posedge clk); #2 abort = 0; layer_ack = 0; hold_env = 0;
    @(negedge clk);
    chk("abort.req_seen", 32'(req_seen), 1);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.layer_req", 32'(layer_req), 0);
    chk("abort.stop_reason", 32'(stop_reason), 0);
    repeat (5) @(negedge clk);
    chk("abort.no_done", 32'(done_n - d0), 0);

    // Asynchronous reset in the middle of a job.
    prm = '{4, 5, 6}; fill_rand(0); start_job(4, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.reqs", 32'({emb_req, layer_req, lnf_req, out_valid, prompt_ready}), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int j = 0; j < 10; j++) begin
      prm.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) prm.push_back(int'($urandom_range(0, 15)));
      fill_rand(j % 2);
      start_job(int'($urandom_range(1, 8)), int'($urandom_range(0, 15)));
      finish_job("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
